// File: rtl/mem_portb_arbiter_pkg.sv
// Shared types and defaults for the memory port-B arbiter.
// Owner and state encodings are fixed so the debug tooling can decode them.
package mem_portb_arbiter_pkg;

   localparam int AW_DEF = 12;
   localparam int DW_DEF = 32;
   localparam int CNT_W  = 8;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_DBG  = 2'd2
   } owner_t;

   typedef enum logic {
      CPU_PRI = 1'b0,
      DBG_PRI = 1'b1
   } arb_state_t;

endpackage

// File: rtl/mem_portb_arbiter_starve_counter.sv
// Counts consecutive cycles a debug request is denied; starve is high on the
// cycle the count has reached MAX_WAIT-1.
module arb_starve_counter
   import mem_portb_arbiter_pkg::*;
#(
   parameter int MAX_WAIT = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic dbg_req,
   input  logic dbg_gnt,
   output logic starve
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_WAIT - 1);

   logic [CNT_W-1:0] wait_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt <= '0;
      end else if (!dbg_req || dbg_gnt) begin
         wait_cnt <= '0;
      end else if (wait_cnt != LAST) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end

   assign starve = (wait_cnt == LAST);

endmodule

// File: rtl/mem_portb_arbiter.sv
// Arbitrates memory port B between the processor and the debug host: one
// combinational grant per cycle, read data returned to its owner a cycle later.
module mem_portb_arbiter
   import mem_portb_arbiter_pkg::*;
#(
   parameter int AW       = AW_DEF,
   parameter int DW       = DW_DEF,
   parameter int MAX_WAIT = 8
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          HLT,
   input  logic          CPU_REQ,
   input  logic          CPU_WE,
   input  logic [AW-1:0] CPU_ADDR,
   input  logic [DW-1:0] CPU_WDATA,
   output logic          CPU_GNT,
   output logic          CPU_RVALID,
   output logic [DW-1:0] CPU_RDATA,
   input  logic          DBG_REQ,
   input  logic          DBG_WE,
   input  logic [AW-1:0] DBG_ADDR,
   input  logic [DW-1:0] DBG_WDATA,
   output logic          DBG_GNT,
   output logic          DBG_RVALID,
   output logic [DW-1:0] DBG_RDATA,
   output logic          WEB,
   output logic [AW-1:0] ADDRB,
   output logic [DW-1:0] DINB,
   input  logic [DW-1:0] DOUTB
);

   arb_state_t state, state_nxt;
   owner_t     rd_owner;
   logic       cpu_win, dbg_win, dbg_first, starve;

   arb_starve_counter #(.MAX_WAIT(MAX_WAIT)) u_starve (
      .clk     (CLK),
      .rst     (RST),
      .dbg_req (DBG_REQ),
      .dbg_gnt (dbg_win),
      .starve  (starve)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= CPU_PRI;
      end else begin
         state <= state_nxt;
      end
   end

   // Grants are suppressed during reset so the memory never sees a stray access.
   always_comb begin
      state_nxt = state;
      cpu_win   = 1'b0;
      dbg_win   = 1'b0;
      dbg_first = HLT || (state == DBG_PRI);
      if (!RST) begin
         if (DBG_REQ && (dbg_first || !CPU_REQ)) begin
            dbg_win = 1'b1;
         end else if (CPU_REQ && !HLT) begin
            cpu_win = 1'b1;
         end
      end
      case (state)
         CPU_PRI: if (DBG_REQ && !dbg_win && starve) state_nxt = DBG_PRI;
         DBG_PRI: if (dbg_win) state_nxt = CPU_PRI;
         default: state_nxt = CPU_PRI;
      endcase
   end

   assign CPU_GNT = cpu_win;
   assign DBG_GNT = dbg_win;

   always_comb begin
      WEB   = 1'b0;
      ADDRB = '0;
      DINB  = '0;
      if (cpu_win) begin
         WEB   = CPU_WE;
         ADDRB = CPU_ADDR;
         DINB  = CPU_WDATA;
      end else if (dbg_win) begin
         WEB   = DBG_WE;
         ADDRB = DBG_ADDR;
         DINB  = DBG_WDATA;
      end
   end

   // Owner of the read now in flight inside the memory; RVALID decodes it.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rd_owner <= OWN_NONE;
      end else if (cpu_win && !CPU_WE) begin
         rd_owner <= OWN_CPU;
      end else if (dbg_win && !DBG_WE) begin
         rd_owner <= OWN_DBG;
      end else begin
         rd_owner <= OWN_NONE;
      end
   end

   assign CPU_RVALID = (rd_owner == OWN_CPU);
   assign DBG_RVALID = (rd_owner == OWN_DBG);
   assign CPU_RDATA  = DOUTB;
   assign DBG_RDATA  = DOUTB;

endmodule

// File: tb/tb_mem_portb_arbiter.sv
// Bench for mem_portb_arbiter: directed scenarios plus random traffic, all
// checked against a transaction-level model of the arbitration rules.
module tb_mem_portb_arbiter;
   localparam int AW = 12;
   localparam int DW = 32;
   localparam int MAX_WAIT = 8;

   logic          CLK = 1'b0;
   logic          RST, HLT;
   logic          CPU_REQ, CPU_WE, CPU_GNT, CPU_RVALID;
   logic [AW-1:0] CPU_ADDR;
   logic [DW-1:0] CPU_WDATA, CPU_RDATA;
   logic          DBG_REQ, DBG_WE, DBG_GNT, DBG_RVALID;
   logic [AW-1:0] DBG_ADDR;
   logic [DW-1:0] DBG_WDATA, DBG_RDATA;
   logic          WEB;
   logic [AW-1:0] ADDRB;
   logic [DW-1:0] DINB, DOUTB;

   mem_portb_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
      .CLK(CLK), .RST(RST), .HLT(HLT),
      .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR), .CPU_WDATA(CPU_WDATA),
      .CPU_GNT(CPU_GNT), .CPU_RVALID(CPU_RVALID), .CPU_RDATA(CPU_RDATA),
      .DBG_REQ(DBG_REQ), .DBG_WE(DBG_WE), .DBG_ADDR(DBG_ADDR), .DBG_WDATA(DBG_WDATA),
      .DBG_GNT(DBG_GNT), .DBG_RVALID(DBG_RVALID), .DBG_RDATA(DBG_RDATA),
      .WEB(WEB), .ADDRB(ADDRB), .DINB(DINB), .DOUTB(DOUTB)
   );

   always #5 CLK = ~CLK;

   // Port-B memory: synchronous, one-cycle read latency.
   logic [DW-1:0] mem     [0:(1<<AW)-1];
   logic [DW-1:0] ref_mem [0:(1<<AW)-1];
   always @(posedge CLK) begin
      if (WEB) mem[ADDRB] <= DINB;
      DOUTB <= mem[ADDRB];
   end

   int checks = 0;
   int failures = 0;

   // Reference model state: consecutive debug denials and the read in flight.
   int            streak;
   int            pend_owner;   // 0 none, 1 cpu, 2 dbg
   logic [DW-1:0] pend_data;
   logic          obs_cgnt, obs_dgnt, obs_cvld, obs_dvld, obs_web;
   logic [DW-1:0] obs_crdata, obs_drdata;
   logic          exp_cgnt_q, exp_dgnt_q;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=0x%0h exp=0x%0h", tag, act, exp);
      end
   endtask

   task automatic model_reset();
      streak     = 0;
      pend_owner = 0;
      pend_data  = '0;
   endtask

   // Checks one cycle against the model, then advances to just after the edge.
   task automatic step();
      logic          ed, ec, ew;
      logic [AW-1:0] ea;
      logic [DW-1:0] edin;
      @(negedge CLK);
      ed   = DBG_REQ && (HLT || streak >= MAX_WAIT || !CPU_REQ);
      ec   = CPU_REQ && !HLT && !ed;
      ew   = 1'b0;
      ea   = '0;
      edin = '0;
      if (ec) begin
         ew = CPU_WE; ea = CPU_ADDR; edin = CPU_WDATA;
      end else if (ed) begin
         ew = DBG_WE; ea = DBG_ADDR; edin = DBG_WDATA;
      end
      check("cpu_gnt", 64'(CPU_GNT), 64'(ec));
      check("dbg_gnt", 64'(DBG_GNT), 64'(ed));
      check("web", 64'(WEB), 64'(ew));
      check("addrb", 64'(ADDRB), 64'(ea));
      check("dinb", 64'(DINB), 64'(edin));
      check("cpu_rvalid", 64'(CPU_RVALID), 64'(pend_owner == 1));
      check("dbg_rvalid", 64'(DBG_RVALID), 64'(pend_owner == 2));
      if (pend_owner == 1) check("cpu_rdata", 64'(CPU_RDATA), 64'(pend_data));
      if (pend_owner == 2) check("dbg_rdata", 64'(DBG_RDATA), 64'(pend_data));
      obs_cgnt = CPU_GNT; obs_dgnt = DBG_GNT; obs_web = WEB;
      obs_cvld = CPU_RVALID; obs_dvld = DBG_RVALID;
      obs_crdata = CPU_RDATA; obs_drdata = DBG_RDATA;
      exp_cgnt_q = ec; exp_dgnt_q = ed;
      pend_owner = 0;
      if ((ec && !CPU_WE) || (ed && !DBG_WE)) begin
         pend_owner = ec ? 1 : 2;
         pend_data  = ref_mem[ea];
      end
      if (ew) ref_mem[ea] = edin;
      streak = (DBG_REQ && !ed) ? streak + 1 : 0;
      @(posedge CLK);
      #1;
   endtask

   task automatic cpu_drive(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      CPU_REQ = req; CPU_WE = we; CPU_ADDR = a; CPU_WDATA = d;
   endtask

   task automatic dbg_drive(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      DBG_REQ = req; DBG_WE = we; DBG_ADDR = a; DBG_WDATA = d;
   endtask

   initial begin
      int dbg_cycle, cpu_before;
      logic g10;
      logic [DW-1:0] v;

      RST = 1'b1; HLT = 1'b0;
      cpu_drive(1'b0, 1'b0, '0, '0);
      dbg_drive(1'b0, 1'b0, '0, '0);
      for (int i = 0; i < (1 << AW); i++) begin
         v = $urandom;
         mem[i] = v; ref_mem[i] = v;
      end
      mem[12'h010] = 32'hDEADBEEF; ref_mem[12'h010] = 32'hDEADBEEF;
      mem[12'h001] = 32'hA5A50001; ref_mem[12'h001] = 32'hA5A50001;
      mem[12'h002] = 32'hA5A50002; ref_mem[12'h002] = 32'hA5A50002;
      model_reset();

      // 1: reset state, idle, and no grants while in reset
      repeat (2) @(posedge CLK);
      #1;
      check("rst_cpu_gnt", 64'(CPU_GNT), 64'd0);
      check("rst_dbg_gnt", 64'(DBG_GNT), 64'd0);
      check("rst_cpu_rvalid", 64'(CPU_RVALID), 64'd0);
      check("rst_dbg_rvalid", 64'(DBG_RVALID), 64'd0);
      check("rst_web", 64'(WEB), 64'd0);
      check("rst_addrb", 64'(ADDRB), 64'd0);
      cpu_drive(1'b1, 1'b1, 12'h055, 32'h1);
      dbg_drive(1'b1, 1'b1, 12'h066, 32'h2);
      #1;
      check("rst_req_cpu_gnt", 64'(CPU_GNT), 64'd0);
      check("rst_req_dbg_gnt", 64'(DBG_GNT), 64'd0);
      check("rst_req_web", 64'(WEB), 64'd0);
      cpu_drive(1'b0, 1'b0, '0, '0);
      dbg_drive(1'b0, 1'b0, '0, '0);
      @(posedge CLK);
      #1;
      RST = 1'b0;
      step();
      step();

      // 2: CPU read
      cpu_drive(1'b1, 1'b0, 12'h010, '0);
      step();
      check("t2_cpu_gnt", 64'(obs_cgnt), 64'd1);
      cpu_drive(1'b0, 1'b0, '0, '0);
      step();
      check("t2_cpu_rvalid", 64'(obs_cvld), 64'd1);
      check("t2_dbg_rvalid", 64'(obs_dvld), 64'd0);
      check("t2_cpu_rdata", 64'(obs_crdata), 64'hDEADBEEF);

      // 3: both held, debug forced through after MAX_WAIT denials
      cpu_drive(1'b1, 1'b0, 12'h005, '0);
      dbg_drive(1'b1, 1'b0, 12'h006, '0);
      dbg_cycle = 0; cpu_before = 0; g10 = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         step();
         if (obs_dgnt && dbg_cycle == 0) dbg_cycle = c;
         if (obs_cgnt && dbg_cycle == 0) cpu_before++;
         if (c == 10) g10 = obs_cgnt;
         if (exp_dgnt_q) DBG_REQ = 1'b0;
      end
      check("t3_dbg_cycle", 64'(dbg_cycle), 64'd9);
      check("t3_cpu_before", 64'(cpu_before), 64'd8);
      check("t3_cycle10_cpu", 64'(g10), 64'd1);
      cpu_drive(1'b0, 1'b0, '0, '0);
      step();

      // 4: halted debug write then read back
      HLT = 1'b1;
      cpu_drive(1'b1, 1'b0, 12'h007, '0);
      dbg_drive(1'b1, 1'b1, 12'h3FF, 32'h12345678);
      step();
      check("t4_dbg_gnt", 64'(obs_dgnt), 64'd1);
      check("t4_cpu_gnt", 64'(obs_cgnt), 64'd0);
      check("t4_web", 64'(obs_web), 64'd1);
      dbg_drive(1'b1, 1'b0, 12'h3FF, '0);
      step();
      dbg_drive(1'b0, 1'b0, '0, '0);
      step();
      check("t4_dbg_rvalid", 64'(obs_dvld), 64'd1);
      check("t4_dbg_rdata", 64'(obs_drdata), 64'h12345678);
      check("t4_halt_cpu_gnt", 64'(obs_cgnt), 64'd0);
      HLT = 1'b0;
      step();
      cpu_drive(1'b0, 1'b0, '0, '0);
      step();

      // 5: back-to-back reads by different owners
      cpu_drive(1'b1, 1'b0, 12'h001, '0);
      step();
      cpu_drive(1'b0, 1'b0, '0, '0);
      dbg_drive(1'b1, 1'b0, 12'h002, '0);
      step();
      check("t5_cpu_rvalid", 64'(obs_cvld), 64'd1);
      check("t5_cpu_rdata", 64'(obs_crdata), 64'hA5A50001);
      dbg_drive(1'b0, 1'b0, '0, '0);
      step();
      check("t5_dbg_rvalid", 64'(obs_dvld), 64'd1);
      check("t5_cpu_rvalid2", 64'(obs_cvld), 64'd0);
      check("t5_dbg_rdata", 64'(obs_drdata), 64'hA5A50002);

      // 6: async reset between grant and return, with debug already waiting
      cpu_drive(1'b1, 1'b0, 12'h010, '0);
      dbg_drive(1'b1, 1'b0, 12'h020, '0);
      step();
      step();
      RST = 1'b1;
      #1;
      check("t6_cpu_rvalid", 64'(CPU_RVALID), 64'd0);
      check("t6_cpu_gnt", 64'(CPU_GNT), 64'd0);
      model_reset();
      @(posedge CLK);
      #1;
      RST = 1'b0;
      dbg_cycle = 0;
      for (int c = 1; c <= 12 && dbg_cycle == 0; c++) begin
         step();
         if (c == 1) check("t6_cpu_pri", 64'(obs_cgnt), 64'd1);
         if (obs_dgnt) dbg_cycle = c;
      end
      check("t6_dbg_cycle", 64'(dbg_cycle), 64'd9);
      cpu_drive(1'b0, 1'b0, '0, '0);
      dbg_drive(1'b0, 1'b0, '0, '0);
      step();

      // Random traffic on a small address window; requests held until granted
      for (int n = 0; n < 1500; n++) begin
         if (!CPU_REQ || exp_cgnt_q)
            cpu_drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      AW'($urandom_range(0, 15)), $urandom);
         if (!DBG_REQ || exp_dgnt_q)
            dbg_drive(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                      AW'($urandom_range(0, 15)), $urandom);
         if ($urandom_range(0, 31) == 0) HLT = ~HLT;
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_portb_arbiter.md
Name: mem_portb_arbiter

Overview:
- Arbitrates the data port (port B) of the shared dual-port instruction/data memory between two requesters: the processor load/store path and a debug host.
- Replaces the static HLT-selected address mux, so the debug host can read and write memory while the processor runs.
- Sits between the processor, the debug interface and memory port B.
- Single-cycle grants, one access per cycle, read data returned one cycle after grant. A starvation counter guarantees debug progress.

Parameters:
- AW, 12: memory word-address width.
- DW, 32: data width.
- MAX_WAIT, 8: consecutive cycles a pending debug request may be denied before it gets forced priority. Legal range 1..255.

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous active-high reset.
- HLT  in  1  processor halted; debug requester has absolute priority.
- CPU_REQ  in  1  processor access request, held until granted.
- CPU_WE  in  1  processor write enable.
- CPU_ADDR  in  AW  processor address.
- CPU_WDATA  in  DW  processor write data.
- CPU_GNT  out  1  processor access accepted this cycle (combinational).
- CPU_RVALID  out  1  processor read data valid (registered).
- CPU_RDATA  out  DW  processor read data.
- DBG_REQ  in  1  debug access request, held until granted.
- DBG_WE  in  1  debug write enable.
- DBG_ADDR  in  AW  debug address.
- DBG_WDATA  in  DW  debug write data.
- DBG_GNT  out  1  debug access accepted this cycle (combinational).
- DBG_RVALID  out  1  debug read data valid (registered).
- DBG_RDATA  out  DW  debug read data.
- WEB  out  1  memory port-B write enable.
- ADDRB  out  AW  memory port-B address.
- DINB  out  DW  memory port-B write data.
- DOUTB  in  DW  memory port-B read data, valid one cycle after address.

Behaviour:
- Reset (async, RST=1): state=CPU_PRI, wait_cnt=0, CPU_RVALID=0, DBG_RVALID=0, rd_owner=NONE. All GNT outputs are 0 while RST=1.
- Arbitration policy: one grant per cycle, at most one of CPU_GNT/DBG_GNT high.
  - HLT=1: DBG_REQ wins. CPU_GNT is forced 0 even if CPU_REQ=1.
  - State CPU_PRI: CPU_REQ wins, else DBG_REQ.
  - State DBG_PRI: DBG_REQ wins, else CPU_REQ.
- FSM:
  - CPU_PRI -> DBG_PRI when DBG_REQ is denied and wait_cnt = MAX_WAIT-1.
  - DBG_PRI -> CPU_PRI on the cycle DBG_GNT=1.
  - HLT does not change state.
- wait_cnt:
  - Increments each cycle DBG_REQ=1 and DBG_GNT=0, saturating at MAX_WAIT-1.
  - Clears on DBG_GNT or when DBG_REQ=0.
- Memory drive (combinational from winner):
  - WEB = winner_WE & GNT.
  - ADDRB and DINB come from the winner.
  - With no grant: WEB=0, ADDRB=0, DINB=0.
- Read return:
  - A granted read (WE=0) records its owner in rd_owner.
  - Next cycle the owner's RVALID=1 and RDATA=DOUTB. The other requester's RVALID=0.
  - RDATA is a pass-through of DOUTB, qualified only by RVALID.
- Writes produce no RVALID.
- Back-to-back: grants are accepted every cycle. A read return and a new grant may coincide.
- Simultaneous same-address access: the winner is served first. The loser sees the memory contents after the winner's write.
- HLT toggling mid-pending: arbitration re-evaluates each cycle. An outstanding read return is still delivered to its recorded owner.
- Reset mid-read: a pending RVALID is dropped (0). No spurious data.

Decomposition:
- Shared package:
  - Owner encoding constants: OWN_NONE=2'd0, OWN_CPU=2'd1, OWN_DBG=2'd2.
  - FSM state constants: CPU_PRI=1'b0, DBG_PRI=1'b1.
  - AW/DW defaults matching the memory.
- One natural sub-module: arb_starve_counter (wait_cnt plus MAX_WAIT compare, outputs a starve flag). Everything else stays flat.

Test Plan:
1. Reset then idle: RST pulse with all REQ=0 -> all GNT=0, RVALID=0, WEB=0, ADDRB=0.
2. CPU read: CPU_REQ=1, CPU_WE=0, CPU_ADDR=0x010, memory[0x010]=0xDEADBEEF -> CPU_GNT=1 same cycle, ADDRB=0x010, next cycle CPU_RVALID=1 and CPU_RDATA=0xDEADBEEF; DBG_RVALID=0.
3. Conflict and starvation: CPU_REQ and DBG_REQ held continuously, MAX_WAIT=8 -> CPU granted 8 cycles, DBG granted in cycle 9, CPU granted again in cycle 10.
4. Halted debug write/read: HLT=1, both requesting, DBG writes 0x12345678 to 0x3FF -> DBG_GNT=1, CPU_GNT=0, WEB=1. DBG then reads 0x3FF -> DBG_RVALID one cycle later with 0x12345678.
5. Back-to-back reads: CPU reads 0x001 then DBG reads 0x002 on consecutive cycles -> CPU_RVALID then DBG_RVALID on consecutive cycles, each with its own address's data.
6. Async reset mid-read: assert RST between grant and return -> CPU_RVALID stays 0 immediately and wait_cnt=0. After release, state is CPU_PRI.
